// File: rtl/round_sat_pipe.sv
// Round-half-up and saturate stage behind the arithmetic right shifter.
// Two-entry valid/ready pipeline with a sticky saturation event counter.
module round_sat_pipe #(
    parameter int DATA_WIDTH = 22,
    parameter int OUT_WIDTH  = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] shifted_i,
    input  logic                  round_bit_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [OUT_WIDTH-1:0]  data_o,
    output logic                  sat_o,
    input  logic                  sat_clr_i,
    output logic [CNT_WIDTH-1:0]  sat_cnt_o
);

    // Output range limits expressed at the widened sum width.
    localparam logic signed [DATA_WIDTH:0] SAT_MAX =
        {{(DATA_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH:0] SAT_MIN =
        {{(DATA_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic                         s1_valid;
    logic signed [DATA_WIDTH:0]   s1_sum;
    logic signed [DATA_WIDTH:0]   sum_next;
    logic                         s2_load;
    logic                         s1_load;
    logic [OUT_WIDTH-1:0]         sat_data;
    logic                         sat_flag;

    assign s2_load = !valid_o || ready_i;
    assign s1_load = !s1_valid || s2_load;
    assign ready_o = s1_load;

    // One extra bit so the most positive input plus the round bit cannot wrap.
    assign sum_next = $signed({shifted_i[DATA_WIDTH-1], shifted_i})
                    + $signed({{DATA_WIDTH{1'b0}}, round_bit_i});

    always_comb begin
        sat_flag = 1'b0;
        sat_data = s1_sum[OUT_WIDTH-1:0];
        if (s1_sum > SAT_MAX) begin
            sat_flag = 1'b1;
            sat_data = SAT_MAX[OUT_WIDTH-1:0];
        end else if (s1_sum < SAT_MIN) begin
            sat_flag = 1'b1;
            sat_data = SAT_MIN[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
        end else if (s1_load) begin
            s1_valid <= valid_i;
            if (valid_i)
                s1_sum <= sum_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            sat_o   <= 1'b0;
        end else if (s2_load) begin
            valid_o <= s1_valid;
            if (s1_valid) begin
                data_o <= sat_data;
                sat_o  <= sat_flag;
            end
        end
    end

    // Clear wins over a same-edge saturated transfer; count sticks at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i || sat_clr_i)
            sat_cnt_o <= '0;
        else if (valid_o && ready_i && sat_o && (sat_cnt_o != {CNT_WIDTH{1'b1}}))
            sat_cnt_o <= sat_cnt_o + CNT_WIDTH'(1);
    end

endmodule

// File: tb/tb_round_sat_pipe.sv
// Scoreboard bench for round_sat_pipe: driver pushes expected results,
// a monitor pops and compares on every output transfer.
module tb_round_sat_pipe;

    localparam int DW = 22;
    localparam int OW = 16;
    localparam longint HI = (64'sd1 <<< (OW-1)) - 1;
    localparam longint LO = -(64'sd1 <<< (OW-1));

    typedef struct { logic [OW-1:0] d; logic s; } exp_t;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          valid_i = 1'b0;
    logic [DW-1:0] shifted_i = '0;
    logic          round_bit_i = 1'b0;
    logic          ready_i;
    logic          sat_clr_i = 1'b0;
    logic          ready_o, valid_o, sat_o;
    logic [OW-1:0] data_o;
    logic [7:0]    sat_cnt_o;
    logic          ready_s, valid_s, sat_s;
    logic [OW-1:0] data_s;
    logic [1:0]    cnt_s;

    int   total = 0;
    int   bad = 0;
    int   rmode = 0;
    bit   mon_en = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    round_sat_pipe #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .CNT_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .shifted_i(shifted_i), .round_bit_i(round_bit_i), .valid_o(valid_o),
        .ready_i(ready_i), .data_o(data_o), .sat_o(sat_o),
        .sat_clr_i(sat_clr_i), .sat_cnt_o(sat_cnt_o));

    // Narrow counter instance fed the same stream, for the stick-at-max case.
    round_sat_pipe #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .CNT_WIDTH(2)) dut_small (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_s),
        .shifted_i(shifted_i), .round_bit_i(round_bit_i), .valid_o(valid_s),
        .ready_i(ready_i), .data_o(data_s), .sat_o(sat_s),
        .sat_clr_i(sat_clr_i), .sat_cnt_o(cnt_s));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer round then clamp.
    function automatic exp_t model(input logic [DW-1:0] v, input logic rb);
        exp_t   r;
        longint s;
        s = longint'($signed(v)) + longint'(rb);
        if (s > HI) begin
            r.d = OW'(HI); r.s = 1'b1;
        end else if (s < LO) begin
            r.d = OW'(LO); r.s = 1'b1;
        end else begin
            r.d = OW'(s); r.s = 1'b0;
        end
        return r;
    endfunction

    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0:       ready_i = 1'b1;
                1:       ready_i = 1'($urandom_range(0, 1));
                default: ready_i = 1'b0;
            endcase
        end
    end

    // Monitor: counters, occupancy-based ready, stall stability, data order.
    initial begin
        int             occ = 0;
        longint         m_big = 0, m_small = 0;
        bit             prev_stall = 0;
        logic [OW-1:0]  prev_d = '0;
        logic           prev_s = 1'b0;
        exp_t           e;
        bit             sat_x;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                q.delete(); occ = 0; m_big = 0; m_small = 0; prev_stall = 0;
                continue;
            end
            if (!mon_en) continue;
            chk("ready", 32'(ready_o), 32'((occ < 2) || ready_i));
            chk("cnt8", 32'(sat_cnt_o), 32'(m_big));
            chk("cnt2", 32'(cnt_s), 32'(m_small));
            if (prev_stall) begin
                chk("stall_valid", 32'(valid_o), 32'd1);
                chk("stall_data", 32'(data_o), 32'(prev_d));
                chk("stall_sat", 32'(sat_o), 32'(prev_s));
            end
            sat_x = 0;
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    chk("extra_output", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("data", 32'(data_o), 32'(e.d));
                    chk("sat", 32'(sat_o), 32'(e.s));
                    sat_x = e.s;
                end
            end
            if (sat_clr_i) begin
                m_big = 0; m_small = 0;
            end else if (sat_x) begin
                if (m_big < 255) m_big++;
                if (m_small < 3) m_small++;
            end
            occ += int'(valid_i && ready_o) - int'(valid_o && ready_i);
            prev_stall = valid_o && !ready_i;
            prev_d = data_o;
            prev_s = sat_o;
        end
    end

    task automatic send(input logic [DW-1:0] v, input logic rb);
        int t = 0;
        valid_i = 1'b1; shifted_i = v; round_bit_i = rb;
        do begin
            @(negedge clk); t++;
        end while (!ready_o && t < 200);
        if (!ready_o) chk("accept_timeout", 32'd0, 32'd1);
        q.push_back(model(v, rb));
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 500) begin
            @(negedge clk); t++;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic set_mode(input int m);
        rmode = m;
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] v;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        mon_en = 1;
        @(negedge clk);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_sat", 32'(sat_o), 32'd0);
        chk("rst_cnt", 32'(sat_cnt_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        @(posedge clk); #1;

        // Sample presented in one cycle appears two cycles later.
        send(22'd1234, 1'b0);
        @(negedge clk);
        chk("lat_early", 32'(valid_o), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(valid_o), 32'd1);
        chk("lat_data", 32'(data_o), 32'd1234);
        drain();

        send(-22'sd5, 1'b1);
        send(22'd32766, 1'b1);
        drain();

        send(22'h1FFFFF, 1'b1);
        send(22'h200000, 1'b0);
        drain();
        chk("cnt_two", 32'(sat_cnt_o), 32'd2);

        sat_clr_i = 1'b1;
        @(posedge clk); #1;
        sat_clr_i = 1'b0;
        for (int i = 0; i < 5; i++) send((i % 2) ? 22'h200000 : 22'd40000, 1'b0);
        drain();
        chk("cnt2_stick", 32'(cnt_s), 32'd3);
        chk("cnt8_five", 32'(sat_cnt_o), 32'd5);

        // Clear on the exact edge of a saturated transfer.
        send(22'd50000, 1'b0);
        @(posedge clk); #1;
        sat_clr_i = 1'b1;
        @(posedge clk); #1;
        sat_clr_i = 1'b0;
        @(negedge clk);
        chk("clr_prio8", 32'(sat_cnt_o), 32'd0);
        chk("clr_prio2", 32'(cnt_s), 32'd0);
        drain();

        set_mode(1);
        for (int i = 0; i < 10; i++) send(DW'(i), 1'b0);
        drain();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end else begin
                case ($urandom_range(0, 3))
                    0:       v = DW'($urandom_range(0, 80000)) - DW'(40000);
                    1:       v = DW'($urandom);
                    2:       v = DW'(32767 + $urandom_range(0, 2) - 1);
                    default: v = DW'(-32768 + $urandom_range(0, 2) - 1);
                endcase
                send(v, 1'($urandom_range(0, 1)));
            end
        end
        drain();

        set_mode(2);
        send(22'd100000, 1'b0);
        send(22'd7, 1'b1);
        @(negedge clk);
        chk("full_ready", 32'(ready_o), 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        rmode = 0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(valid_o), 32'd0);
        chk("mid_rst_ready", 32'(ready_o), 32'd1);
        chk("mid_rst_cnt", 32'(sat_cnt_o), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
